// File: rtl/port_addr_decoder.sv
// -----------------------------------------------------------------------------
// port_addr_decoder
//   Decodes processor port_id accesses into registered one-hot read/write
//   selects for NPORT peripherals. It also returns the selected peripheral's
//   16-bit read word and keeps a sticky error flag for unmapped or conflicting
//   accesses.
//
// Parameters
//   AW     port_id width (4..16)
//   NPORT  number of decoded ports, a power of 2 (2..2^AW)
//   BASE   base address; only bits [AW-1:log2(NPORT)] take part in the match
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   port_id       in   [AW-1:0]       access address
//   read_strobe   in   single-cycle read request
//   write_strobe  in   single-cycle write request
//   rd_bus        in   [NPORT*16-1:0] peripheral read data, port k at [16k+15:16k]
//   err_clr       in   clears the sticky error and the hit counter
//   read          out  [NPORT-1:0]    registered one-hot read select
//   write         out  [NPORT-1:0]    registered one-hot write select
//   in_port       out  [15:0]         registered read data
//   err           out  sticky access-error flag
//   err_code      out  [1:0]          last error cause: 01 unmapped, 10 conflict
//   hit_cnt       out  [15:0]         saturating count of successful decodes
//                                     (present only with DECODE_CNT_EN)
//
// Configuration macro
//   DECODE_CNT_EN  adds the hit_cnt output and its counter.
// -----------------------------------------------------------------------------
module port_addr_decoder #(
  parameter int              AW    = 16,
  parameter int              NPORT = 16,
  parameter logic [AW-1:0]   BASE  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        port_id,
  input  logic                 read_strobe,
  input  logic                 write_strobe,
  input  logic [NPORT*16-1:0]  rd_bus,
  input  logic                 err_clr,
  output logic [NPORT-1:0]     read,
  output logic [NPORT-1:0]     write,
  output logic [15:0]          in_port,
  output logic                 err,
  output logic [1:0]           err_code
`ifdef DECODE_CNT_EN
  ,
  output logic [15:0]          hit_cnt
`endif
);

  localparam int SEL_W = $clog2(NPORT);

  // Low address bits that select the port inside the window; everything
  // above them must match BASE. Built as a mask so the SEL_W == AW case
  // (whole address space is one window) needs no special slice.
  localparam logic [AW-1:0] LO_MASK = AW'((1 << SEL_W) - 1);

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_CONFLICT = 2'b10
  } err_code_t;

  logic              hit;
  logic [SEL_W-1:0]  idx;
  logic              conflict;
  logic              miss;
  logic              rd_ok;
  logic              wr_ok;
  logic [NPORT-1:0]  sel_onehot;
  logic [15:0]       rd_word;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_onehot = '0;
    hit        = ((port_id ^ BASE) & ~LO_MASK) == '0;
    idx        = port_id[SEL_W-1:0];
    conflict   = read_strobe & write_strobe;
    // Exactly one strobe is required before the address matters at all.
    miss       = (read_strobe ^ write_strobe) & ~hit;
    rd_ok      = hit & read_strobe & ~write_strobe;
    wr_ok      = hit & write_strobe & ~read_strobe;
    sel_onehot[idx] = 1'b1;
    rd_word    = rd_bus[{idx, 4'b0000} +: 16];
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read     <= '0;
      write    <= '0;
      in_port  <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      // Selects are single-cycle pulses: anything but a clean hit clears them.
      read  <= rd_ok ? sel_onehot : '0;
      write <= wr_ok ? sel_onehot : '0;

      if (rd_ok) begin
        in_port <= rd_word;
      end

      // A new error takes priority over err_clr in the same cycle.
      if (conflict) begin
        err      <= 1'b1;
        err_code <= ERR_CONFLICT;
      end else if (miss) begin
        err      <= 1'b1;
        err_code <= ERR_UNMAPPED;
      end else if (err_clr) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

`ifdef DECODE_CNT_EN
  // Counts successful decodes. A clear in the same cycle as a hit restarts
  // the count at 1, so that hit is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt <= '0;
    end else if (err_clr) begin
      hit_cnt <= (rd_ok | wr_ok) ? 16'd1 : 16'd0;
    end else if ((rd_ok | wr_ok) && (hit_cnt != 16'hFFFF)) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_port_addr_decoder.sv
// -----------------------------------------------------------------------------
// tb_port_addr_decoder
//   Self-checking bench for port_addr_decoder. Instance "a" uses the defaults
//   (AW=16, NPORT=16, BASE=0). Instance "b" uses NPORT=4, BASE=16'h0040.
//   The bench applies a table of directed vectors, hand-written multi-cycle
//   sequences, and randomized accesses. All results are compared against
//   an address-arithmetic reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_port_addr_decoder;

  localparam logic [15:0] BASE_A = 16'h0000;

  logic          clk;
  logic          reset;

  // Instance a (defaults)
  logic [15:0]   port_id;
  logic          read_strobe;
  logic          write_strobe;
  logic [255:0]  rd_bus;
  logic          err_clr;
  logic [15:0]   read;
  logic [15:0]   write;
  logic [15:0]   in_port;
  logic          err;
  logic [1:0]    err_code;
  logic [15:0]   hit_cnt;

  // Instance b (NPORT=4, BASE=0x0040)
  logic [15:0]   b_port_id;
  logic          b_read_strobe;
  logic          b_write_strobe;
  logic [63:0]   b_rd_bus;
  logic          b_err_clr;
  logic [3:0]    b_read;
  logic [3:0]    b_write;
  logic [15:0]   b_in_port;
  logic          b_err;
  logic [1:0]    b_err_code;
  logic [15:0]   b_hit_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state for instance a
  logic [15:0] m_in;
  logic        m_err;
  logic [1:0]  m_code;
  int          m_cnt;

  port_addr_decoder dut_a (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .rd_bus       (rd_bus),
    .err_clr      (err_clr),
    .read         (read),
    .write        (write),
    .in_port      (in_port),
    .err          (err),
`ifdef DECODE_CNT_EN
    .hit_cnt      (hit_cnt),
`endif
    .err_code     (err_code)
  );

  port_addr_decoder #(.AW(16), .NPORT(4), .BASE(16'h0040)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .port_id      (b_port_id),
    .read_strobe  (b_read_strobe),
    .write_strobe (b_write_strobe),
    .rd_bus       (b_rd_bus),
    .err_clr      (b_err_clr),
    .read         (b_read),
    .write        (b_write),
    .in_port      (b_in_port),
    .err          (b_err),
`ifdef DECODE_CNT_EN
    .hit_cnt      (b_hit_cnt),
`endif
    .err_code     (b_err_code)
  );

`ifndef DECODE_CNT_EN
  assign hit_cnt   = '0;
  assign b_hit_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_in   = '0;
    m_err  = 1'b0;
    m_code = 2'b00;
    m_cnt  = 0;
  endtask

  // One access on instance a: predict from the address rules, clock, compare.
  task automatic step_a(input logic [15:0] pid, input bit rs, input bit ws, input bit clr);
    bit           hit;
    int           idx;
    int           exp_rd;
    int           exp_wr;
    logic [255:0] shifted;
    port_id      = pid;
    read_strobe  = rs;
    write_strobe = ws;
    err_clr      = clr;
    hit    = (int'(pid) / 16) == (int'(BASE_A) / 16);
    idx    = int'(pid) % 16;
    exp_rd = 0;
    exp_wr = 0;
    if (rs && ws) begin
      m_err  = 1'b1;
      m_code = 2'b10;
    end else if ((rs || ws) && !hit) begin
      m_err  = 1'b1;
      m_code = 2'b01;
    end else begin
      if (rs && hit) begin
        exp_rd  = 1 << idx;
        shifted = rd_bus >> (16 * idx);
        m_in    = shifted[15:0];
      end
      if (ws && hit) exp_wr = 1 << idx;
      if (clr) begin
        m_err  = 1'b0;
        m_code = 2'b00;
      end
    end
    if (clr) m_cnt = (exp_rd != 0 || exp_wr != 0) ? 1 : 0;
    else if ((exp_rd != 0 || exp_wr != 0) && m_cnt < 65535) m_cnt++;
    @(posedge clk);
    #1;
    check("model read",     32'(read),     exp_rd);
    check("model write",    32'(write),    exp_wr);
    check("model in_port",  32'(in_port),  32'(m_in));
    check("model err",      32'(err),      32'(m_err));
    check("model err_code", 32'(err_code), 32'(m_code));
`ifdef DECODE_CNT_EN
    check("model hit_cnt",  32'(hit_cnt),  m_cnt);
`endif
  endtask

  typedef struct {
    logic [15:0] pid;
    bit          rs;
    bit          ws;
    bit          clr;
    logic [15:0] rd;
    logic [15:0] wr;
    logic [15:0] inp;
    bit          er;
    logic [1:0]  code;
  } vec_t;

  vec_t tbl[16];

  initial begin
    reset = 1'b1;
    port_id = '0; read_strobe = 0; write_strobe = 0; err_clr = 0;
    b_port_id = '0; b_read_strobe = 0; b_write_strobe = 0; b_err_clr = 0;
    for (int k = 0; k < 16; k++) rd_bus[16*k +: 16] = 16'hA000 + 16'(k);
    for (int k = 0; k < 4; k++)  b_rd_bus[16*k +: 16] = 16'hB000 + 16'(k);
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset read",     32'(read),     0);
    check("reset write",    32'(write),    0);
    check("reset in_port",  32'(in_port),  0);
    check("reset err",      32'(err),      0);
    check("reset err_code", 32'(err_code), 0);
    check("reset b_write",  32'(b_write),  0);
`ifdef DECODE_CNT_EN
    check("reset hit_cnt",  32'(hit_cnt),  0);
`endif
    reset = 1'b0;

    // Directed table: {pid, rs, ws, clr, read, write, in_port, err, err_code}
    tbl[0]  = '{16'h0005, 1, 0, 0, 16'h0020, 16'h0000, 16'hA005, 0, 2'b00};
    tbl[1]  = '{16'h0005, 0, 0, 0, 16'h0000, 16'h0000, 16'hA005, 0, 2'b00};
    tbl[2]  = '{16'h0010, 0, 1, 0, 16'h0000, 16'h0000, 16'hA005, 1, 2'b01};
    tbl[3]  = '{16'h0003, 0, 0, 0, 16'h0000, 16'h0000, 16'hA005, 1, 2'b01};
    tbl[4]  = '{16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 16'hA005, 0, 2'b00};
    tbl[5]  = '{16'h000F, 1, 1, 0, 16'h0000, 16'h0000, 16'hA005, 1, 2'b10};
    tbl[6]  = '{16'h000F, 0, 1, 1, 16'h0000, 16'h8000, 16'hA005, 0, 2'b00};
    tbl[7]  = '{16'h000F, 1, 0, 0, 16'h8000, 16'h0000, 16'hA00F, 0, 2'b00};
    tbl[8]  = '{16'hFFF0, 1, 0, 0, 16'h0000, 16'h0000, 16'hA00F, 1, 2'b01};
    tbl[9]  = '{16'h0000, 0, 1, 1, 16'h0000, 16'h0001, 16'hA00F, 0, 2'b00};
    tbl[10] = '{16'h0007, 0, 1, 0, 16'h0000, 16'h0080, 16'hA00F, 0, 2'b00};
    tbl[11] = '{16'h0008, 1, 0, 0, 16'h0100, 16'h0000, 16'hA008, 0, 2'b00};
    tbl[12] = '{16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 16'hA008, 0, 2'b00};
    tbl[13] = '{16'h0020, 1, 1, 1, 16'h0000, 16'h0000, 16'hA008, 1, 2'b10};
    tbl[14] = '{16'h0021, 0, 1, 1, 16'h0000, 16'h0000, 16'hA008, 1, 2'b01};
    tbl[15] = '{16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 16'hA008, 0, 2'b00};

    for (int i = 0; i < 16; i++) begin
      step_a(tbl[i].pid, tbl[i].rs, tbl[i].ws, tbl[i].clr);
      check($sformatf("tbl[%0d] read", i),     32'(read),     32'(tbl[i].rd));
      check($sformatf("tbl[%0d] write", i),    32'(write),    32'(tbl[i].wr));
      check($sformatf("tbl[%0d] in_port", i),  32'(in_port),  32'(tbl[i].inp));
      check($sformatf("tbl[%0d] err", i),      32'(err),      32'(tbl[i].er));
      check($sformatf("tbl[%0d] err_code", i), 32'(err_code), 32'(tbl[i].code));
    end

    // Instance b: back-to-back writes across its 4-port window, then a miss.
    for (int i = 0; i < 4; i++) begin
      b_port_id = 16'h0040 + 16'(i);
      b_write_strobe = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("b write 0x%0h", 16'h0040 + i), 32'(b_write), 32'(1 << i));
      check("b read idle", 32'(b_read), 0);
    end
    b_port_id = 16'h0044;
    @(posedge clk);
    #1;
    check("b miss write", 32'(b_write),    0);
    check("b miss err",   32'(b_err),      1);
    check("b miss code",  32'(b_err_code), 1);
    b_write_strobe = 1'b0;
    b_read_strobe  = 1'b1;
    b_err_clr      = 1'b1;
    b_port_id      = 16'h0042;
    @(posedge clk);
    #1;
    check("b read sel",     32'(b_read),    32'h4);
    check("b read in_port", 32'(b_in_port), 32'hB002);
    check("b clr err",      32'(b_err),     0);
`ifdef DECODE_CNT_EN
    check("b hit_cnt clr+hit", 32'(b_hit_cnt), 1);
`endif
    b_read_strobe = 1'b0;
    b_err_clr     = 1'b0;
    @(posedge clk);
    #1;
    check("b read drops", 32'(b_read), 0);

    // Reset one cycle after a hit strobe: the select clears at once and the
    // access does not resume.
    step_a(16'h0005, 1, 0, 0);
    read_strobe = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset read",    32'(read),    0);
    check("midreset in_port", 32'(in_port), 0);
    check("midreset err",     32'(err),     0);
    model_reset();
    @(posedge clk);
    #1;
    check("inreset read", 32'(read), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("postreset read",  32'(read),  0);
    check("postreset write", 32'(write), 0);

    // Randomized accesses against the model.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] pid;
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < 16; k++) rd_bus[16*k +: 16] = 16'($urandom);
      pid = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      step_a(pid, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
             $urandom_range(0, 9) == 0);
    end

`ifdef DECODE_CNT_EN
    // Counter saturation: 70000 consecutive hits.
    step_a(16'h0000, 0, 0, 1);
    read_strobe = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      port_id = 16'(i % 16);
      @(posedge clk);
      #1;
    end
    read_strobe = 1'b0;
    check("hit_cnt saturate", 32'(hit_cnt), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/port_addr_decoder.md
PORT_ADDR_DECODER -- requirements
Module: port_addr_decoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter AW, default 16: port_id width in bits, range 4..16.
REQ-003 Parameter NPORT, default 16: number of decoded ports, a power of 2, range 2..2^AW; SEL_W = log2(NPORT).
REQ-004 Parameter BASE, default 0 (AW bits): base address; only bits [AW-1:SEL_W] are compared.
REQ-005 clk  in  1  system clock; all state SHALL change on the rising edge only.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 port_id  in  AW  port address from the processor.
REQ-008 read_strobe  in  1  read request; valid for one cycle.
REQ-009 write_strobe  in  1  write request; valid for one cycle.
REQ-010 rd_bus  in  NPORT*16  peripheral read data; port k occupies bits [16k+15:16k].
REQ-011 err_clr  in  1  clears the sticky error and counter state.
REQ-012 read  out  NPORT  registered one-hot read select.
REQ-013 write  out  NPORT  registered one-hot write select.
REQ-014 in_port  out  16  registered read data returned to the processor.
REQ-015 err  out  1  sticky access-error flag.
REQ-016 err_code  out  2  cause of the last error: 01 = unmapped, 10 = read/write conflict.

Function
REQ-017 Hit SHALL be defined as port_id[AW-1:SEL_W] == BASE[AW-1:SEL_W]; idx SHALL be port_id[SEL_W-1:0].
REQ-018 On a hit with exactly one strobe, the matching read[idx] or write[idx] bit SHALL be 1 for exactly one cycle, starting the cycle after the strobe (latency 1).
REQ-019 read and write SHALL be all-zero in every other cycle, and at most one bit of the two vectors together SHALL be set.
REQ-020 On a hit read, in_port SHALL load rd_bus[16*idx+15:16*idx] in the same edge that asserts read[idx]. in_port SHALL hold its value otherwise.
REQ-021 A strobe on a miss SHALL produce no select, leave in_port unchanged, set err and set err_code=01.
REQ-022 read_strobe and write_strobe asserted together SHALL produce no select, set err and set err_code=10, whether the address hits or misses.
REQ-023 Strobes on consecutive cycles SHALL each be decoded independently; back-to-back throughput is one access per cycle.
REQ-024 err SHALL stay high until err_clr is sampled high.
REQ-025 If err_clr is high in the same cycle as a new error, the set SHALL win and err_code SHALL take the new cause.
REQ-026 With no strobe asserted, port_id SHALL be ignored.

Reset
REQ-027 While reset is high, read, write, in_port, err and err_code SHALL be 0, as SHALL hit_cnt when it is present.
REQ-028 Reset asserted mid-access SHALL immediately clear any pending select; the access SHALL be dropped and SHALL not resume after reset.

Configuration
REQ-029 Macro DECODE_CNT_EN: when defined, the block SHALL add output hit_cnt (16 bits).
REQ-030 With DECODE_CNT_EN defined, hit_cnt SHALL increment by 1 on each successful decode and saturate at 16'hFFFF.
REQ-031 With DECODE_CNT_EN defined, err_clr SHALL zero hit_cnt; if err_clr coincides with a hit, hit_cnt SHALL become 1.
REQ-032 When DECODE_CNT_EN is undefined, the hit_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Defaults, BASE=0: port_id=16'h0005, read_strobe pulse -> next cycle read=16'h0020, write=0, in_port=rd_bus[95:80]; then all-zero.
REQ-034 Defaults, BASE=0: port_id=16'h0010, write_strobe -> write=0, err=1, err_code=01; err stays high until err_clr, then reads 0.
REQ-035 port_id=16'h000F with read_strobe and write_strobe both high -> read=write=0, err_code=10.
REQ-036 NPORT=4, BASE=16'h0040, writes to 16'h0040..16'h0043 on consecutive cycles -> write=0001, 0010, 0100, 1000 on consecutive cycles; 16'h0044 -> err.
REQ-037 Reset pulsed one cycle after a hit strobe -> read=0 and no select appears; with DECODE_CNT_EN defined, 70000 hits -> hit_cnt=16'hFFFF.
